reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   MIPS general-purpose register file. It is the consumer of the write address
//   (rw) selected upstream by the RegDst mux. It stores 32 x 32-bit registers and
//   has two combinational read ports (rs/rt operands) and one synchronous write port.
//   Optional same-cycle write-to-read bypass. Register $0 reads as zero.
//   Sits between decode (ra/rb from instr[25:21]/[20:16]) and the ALU / write-back path.
// PARAMETERS
//   DATA_W  32  width of each register and of busA/busB/busW
//   ADDR_W  5   register address width; depth = 2**ADDR_W
//   BYPASS  1   1: a read of the register being written returns busW in the same cycle
// PORTS
//   clk      in   1       rising-edge clock; the only clock
//   rst_n    in   1       synchronous active-low reset, sampled on rising clk
//   ra       in   ADDR_W  read address A (rs)
//   rb       in   ADDR_W  read address B (rt)
//   busA     out  DATA_W  data of register ra
//   busB     out  DATA_W  data of register rb
//   rw       in   ADDR_W  write address (from RegDst selection)
//   busW     in   DATA_W  write data (from MemtoReg selection)
//   RegWr    in   1       write enable
//   dbg_addr in   ADDR_W  debug/inspection read address
//   dbg_data out  DATA_W  data of register dbg_addr; never bypassed
//   wr_cnt   out  32      number of committed writes since reset; wraps at 2**32
// BEHAVIOUR
//   - Reset: synchronous and active-low. On a rising clk with rst_n=0, all registers
//     are cleared to 0, wr_cnt is cleared to 0, and any write in that cycle is dropped.
//     busA, busB and dbg_data therefore read 0 from the next cycle onward.
//   - Write: on a rising clk with rst_n=1, RegWr=1 and rw!=0, mem[rw] <= busW and
//     wr_cnt <= wr_cnt+1. A write with rw==0 is discarded and not counted.
//     RegWr=0: nothing changes.
//   - Read: busA/busB are combinational, with zero-cycle latency from ra/rb.
//     ra==0 returns 0 regardless of any write.
//   - Bypass (BYPASS=1): if RegWr=1, rw!=0, rw==ra and rst_n=1, busA=busW in the
//     same cycle. busB behaves the same with rb. When ra==rb==rw, both ports bypass.
//     With BYPASS=0, reads return the stored value; the new value appears the
//     cycle after the edge.
//   - During an active reset cycle (rst_n=0), reads return stored contents and
//     the bypass is suppressed.
//   - dbg_data = (dbg_addr==0) ? 0 : mem[dbg_addr]. It is combinational and has
//     no bypass.
//   - Widths: addresses are unsigned. No sign or zero extension happens here.
//     busW is stored as given.
// STRUCTURE
//   - Shared package/header (mips_defs): REG_ZERO=5'd0, REG_RA=5'd31, DATA_W, ADDR_W.
//   - One natural sub-module: rf_read_port (address compare, zero force, bypass mux).
//     It is instantiated twice, for A and B; the debug port uses it with bypass tied off.
//   - Storage is a reg array; $0 is not physically written.
// TESTING
//   1. Reset: write 0xDEADBEEF to $5, then hold rst_n=0 for 1 clk.
//      -> dbg_data($5)=0, busA($5)=0, wr_cnt=0.
//   2. Basic write/read: RegWr=1, rw=8, busW=0x12345678, 1 clk; then ra=8, rb=8.
//      -> busA=busB=0x12345678, wr_cnt=1.
//   3. $0 protection: RegWr=1, rw=0, busW=0xFFFFFFFF; ra=0.
//      -> busA=0 before and after the edge, wr_cnt unchanged.
//   4. Bypass: $9 holds 0x11; in the same cycle RegWr=1, rw=9, busW=0x22, ra=9, rb=9.
//      -> busA=busB=0x22 before the edge (BYPASS=1); 0x11 before the edge with BYPASS=0.
//   5. Reset mid-write: rst_n=0, RegWr=1, rw=3, busW=0x55.
//      -> after the edge $3=0, wr_cnt=0, and no bypass during that cycle.
//   6. Sweep: write reg i = i*0x01010101 for i=1..31, then read back on A, B and dbg.
//      -> all match, wr_cnt=31.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file definitions: architectural widths and special register numbers.
package reg_file_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_rf_read_port.sv
// One read port: zero-forces $0 and optionally forwards the in-flight write data.
module reg_file_rf_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              wr_fire,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data
);

    // wr_fire already excludes reset cycles and writes to $0
    always_comb begin
        data = stored;
        if (BYPASS && wr_fire && (addr == wr_addr)) begin
            data = wr_data;
        end
        if (addr == ADDR_W'(REG_ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// MIPS 32x32 register file: two combinational read ports, one synchronous write port,
// a non-bypassed debug read port and a committed-write counter.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
    parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] busW,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       wr_cnt
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [Depth];
    logic [31:0]       wr_cnt_q;
    logic              wr_fire;

    assign wr_fire = rst_n && RegWr && (rw != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
            wr_cnt_q <= '0;
        end else if (wr_fire) begin
            mem[rw]  <= busW;
            wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign wr_cnt = wr_cnt_q;

    reg_file_rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS != 0)
    ) u_port_a (
        .addr    (ra),
        .stored  (mem[ra]),
        .wr_fire (wr_fire),
        .wr_addr (rw),
        .wr_data (busW),
        .data    (busA)
    );

    reg_file_rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS != 0)
    ) u_port_b (
        .addr    (rb),
        .stored  (mem[rb]),
        .wr_fire (wr_fire),
        .wr_addr (rw),
        .wr_data (busW),
        .data    (busB)
    );

    reg_file_rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (1'b0)
    ) u_port_dbg (
        .addr    (dbg_addr),
        .stored  (mem[dbg_addr]),
        .wr_fire (wr_fire),
        .wr_addr (rw),
        .wr_data (busW),
        .data    (dbg_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic
// compared against an array-based model of the register file.
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra, rb, rw, dbg_addr;
    logic [31:0] busA, busB, busW, dbg_data, wr_cnt;
    logic        RegWr;

    int unsigned ncmp;
    int unsigned nerr;

    logic [31:0] model [32];
    logic [31:0] model_cnt;

    reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rb       (rb),
        .busA     (busA),
        .busB     (busB),
        .rw       (rw),
        .busW     (busW),
        .RegWr    (RegWr),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the architectural rules for the edge that is about to happen.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
            model_cnt = '0;
        end else if (RegWr && rw != 5'd0) begin
            model[rw] = busW;
            model_cnt = model_cnt + 32'd1;
        end
        #1;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
        if (addr == 5'd0) return '0;
        if (byp && rst_n && RegWr && rw != 5'd0 && rw == addr) return busW;
        return model[addr];
    endfunction

    initial begin
        ncmp = 0;
        nerr = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_cnt = '0;
        rst_n = 1'b0; RegWr = 1'b0; ra = '0; rb = '0; rw = '0; busW = '0; dbg_addr = '0;
        step();
        rst_n = 1'b1;

        // Reset clears earlier writes and the counter
        RegWr = 1'b1; rw = 5'd5; busW = 32'hDEADBEEF;
        step();
        RegWr = 1'b0; dbg_addr = 5'd5; #1;
        check("pre_reset_dbg5", dbg_data, 32'hDEADBEEF);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; ra = 5'd5; #1;
        check("reset_dbg5", dbg_data, 32'h0);
        check("reset_busA5", busA, 32'h0);
        check("reset_cnt", wr_cnt, 32'd0);

        // Basic write then read on both ports
        RegWr = 1'b1; rw = 5'd8; busW = 32'h12345678;
        step();
        RegWr = 1'b0; ra = 5'd8; rb = 5'd8; #1;
        check("basic_busA", busA, 32'h12345678);
        check("basic_busB", busB, 32'h12345678);
        check("basic_cnt", wr_cnt, 32'd1);

        // Writes to $0 are discarded and never bypassed
        RegWr = 1'b1; rw = 5'd0; busW = 32'hFFFFFFFF; ra = 5'd0; #1;
        check("zero_busA_pre", busA, 32'h0);
        step();
        RegWr = 1'b0; #1;
        check("zero_busA_post", busA, 32'h0);
        check("zero_cnt", wr_cnt, 32'd1);

        // Same-cycle bypass on both ports; debug port sees the old value
        RegWr = 1'b1; rw = 5'd9; busW = 32'h11;
        step();
        busW = 32'h22; ra = 5'd9; rb = 5'd9; dbg_addr = 5'd9; #1;
        check("bypass_busA", busA, 32'h22);
        check("bypass_busB", busB, 32'h22);
        check("bypass_dbg_old", dbg_data, 32'h11);
        step();
        RegWr = 1'b0; #1;
        check("bypass_dbg_new", dbg_data, 32'h22);

        // Reset during a write: write dropped, bypass suppressed
        RegWr = 1'b1; rw = 5'd3; busW = 32'h77;
        step();
        rst_n = 1'b0; busW = 32'h55; ra = 5'd3; rb = 5'd3; dbg_addr = 5'd3; #1;
        check("rstwr_busA_nobyp", busA, 32'h77);
        check("rstwr_busB_nobyp", busB, 32'h77);
        step();
        rst_n = 1'b1; RegWr = 1'b0; #1;
        check("rstwr_dbg3", dbg_data, 32'h0);
        check("rstwr_cnt", wr_cnt, 32'd0);

        // Sweep every writable register
        RegWr = 1'b1;
        for (int i = 1; i <= int'(REG_RA); i++) begin
            rw = 5'(i); busW = 32'(i) * 32'h01010101;
            step();
        end
        RegWr = 1'b0;
        for (int i = 1; i <= int'(REG_RA); i++) begin
            ra = 5'(i); rb = 5'(32 - i); dbg_addr = 5'(i); #1;
            check($sformatf("sweep_busA_%0d", i), busA, 32'(i) * 32'h01010101);
            check($sformatf("sweep_busB_%0d", 32 - i), busB, 32'(32 - i) * 32'h01010101);
            check($sformatf("sweep_dbg_%0d", i), dbg_data, 32'(i) * 32'h01010101);
        end
        check("sweep_cnt", wr_cnt, 32'd31);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            RegWr    = ($urandom_range(0, 3) != 0);
            rw       = 5'($urandom_range(0, 31));
            ra       = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            rb       = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            dbg_addr = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            busW     = $urandom;
            #1;
            check("rand_busA", busA, exp_read(ra, 1'b1));
            check("rand_busB", busB, exp_read(rb, 1'b1));
            check("rand_dbg", dbg_data, exp_read(dbg_addr, 1'b0));
            check("rand_cnt", wr_cnt, model_cnt);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
